// File: rtl/title_pkg.sv
// Shared definitions for the title-text path (loader -> VGA display).
// Provides title geometry, the framing control bytes, the loader FSM state
// type and the char mapping that keeps every stored byte in 0x20..0x5F.
package title_pkg;

  localparam int unsigned TITLE_CHARS = 10;
  localparam int unsigned TITLE_SLOTS = 3;
  localparam int unsigned CHAR_W      = 8;
  localparam int unsigned TITLE_W     = TITLE_CHARS * CHAR_W;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned SLOT_W      = 2;

  localparam logic [CHAR_W-1:0] CH_SOH   = 8'h01;
  localparam logic [CHAR_W-1:0] CH_LF    = 8'h0A;
  localparam logic [CHAR_W-1:0] CH_CR    = 8'h0D;
  localparam logic [CHAR_W-1:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLOT   = 2'd1,
    CHARS  = 2'd2,
    COMMIT = 2'd3
  } title_state_t;

  // Fold a printable byte into the display's glyph range: lowercase becomes
  // uppercase, the few glyphs above 0x5F that have no uppercase twin become '?'.
  function automatic logic [CHAR_W-1:0] map_char(input logic [CHAR_W-1:0] c);
    logic [CHAR_W-1:0] m;
    if (c >= 8'h61 && c <= 8'h7A) begin
      m = c - 8'h20;
    end else if (c == 8'h60 || c >= 8'h7B) begin
      m = 8'h3F;
    end else begin
      m = c;
    end
    return m;
  endfunction

endpackage

// File: rtl/title_loader.sv
// title_loader: parses framed title records from a byte stream and commits
// each one atomically into one of three 80-bit ASCII title registers.
// Record: SOH, slot '0'..'2', 0..10 chars, LF/CR (10th char ends implicitly).
// Ports:
//   clk_pix            pixel clock
//   rst_pix            synchronous active-high reset
//   frame              start-of-frame pulse (commit alignment when SYNC_COMMIT)
//   rx_data/rx_valid   incoming byte stream; rx_ready back-pressure
//   titles[2:0]        packed titles, char 0 in [79:72]
//   title_upd/upd_slot one-cycle pulse + slot index on each commit
//   frame_err          one-cycle pulse on a protocol error
//   busy               FSM is not idle
module title_loader
  import title_pkg::*;
#(
  parameter bit                 SYNC_COMMIT = 1'b1,
  parameter logic [TITLE_W-1:0] INIT0       = {TITLE_CHARS{CH_SPACE}},
  parameter logic [TITLE_W-1:0] INIT1       = {TITLE_CHARS{CH_SPACE}},
  parameter logic [TITLE_W-1:0] INIT2       = {TITLE_CHARS{CH_SPACE}}
) (
  input  logic                                clk_pix,
  input  logic                                rst_pix,
  input  logic                                frame,
  input  logic [CHAR_W-1:0]                   rx_data,
  input  logic                                rx_valid,
  output logic                                rx_ready,
  output logic [TITLE_SLOTS-1:0][TITLE_W-1:0] titles,
  output logic                                title_upd,
  output logic [SLOT_W-1:0]                   upd_slot,
  output logic                                frame_err,
  output logic                                busy
);

  title_state_t                        state_q, state_d;
  logic [SLOT_W-1:0]                   slot_q, slot_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [TITLE_W-1:0]                  shadow_q, shadow_d;
  logic [TITLE_SLOTS-1:0][TITLE_W-1:0] titles_q, titles_d;
  logic                                title_upd_q, title_upd_d;
  logic [SLOT_W-1:0]                   upd_slot_q, upd_slot_d;
  logic                                frame_err_q, frame_err_d;
  logic                                rx_ready_q, rx_ready_d;
  logic                                busy_q, busy_d;

  logic accept;
  logic is_slot;
  logic is_term;
  logic is_print;

  assign accept   = rx_valid && rx_ready_q;
  assign is_slot  = (rx_data >= 8'h30) && (rx_data <= 8'h32);
  assign is_term  = (rx_data == CH_LF) || (rx_data == CH_CR);
  assign is_print = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    titles_d    = titles_q;
    title_upd_d = 1'b0;
    upd_slot_d  = upd_slot_q;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && rx_data == CH_SOH) begin
          state_d = SLOT;
        end
      end

      SLOT: begin
        if (accept) begin
          if (is_slot) begin
            // '0'..'2' are 0x30..0x32, so the low bits are the slot index.
            slot_d   = rx_data[SLOT_W-1:0];
            shadow_d = {TITLE_CHARS{CH_SPACE}};
            cnt_d    = '0;
            state_d  = CHARS;
          end else if (rx_data == CH_SOH) begin
            state_d = SLOT;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      CHARS: begin
        if (accept) begin
          if (is_term) begin
            state_d = COMMIT;
          end else if (rx_data == CH_SOH) begin
            frame_err_d = 1'b1;
            state_d     = SLOT;
          end else if (is_print) begin
            for (int unsigned i = 0; i < TITLE_CHARS; i++) begin
              if (cnt_q == CNT_W'(i)) begin
                shadow_d[TITLE_W-1-CHAR_W*i -: CHAR_W] = map_char(rx_data);
              end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TITLE_CHARS - 1)) begin
              state_d = COMMIT;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      COMMIT: begin
        if (!SYNC_COMMIT || frame) begin
          for (int unsigned k = 0; k < TITLE_SLOTS; k++) begin
            if (slot_q == SLOT_W'(k)) begin
              titles_d[k] = shadow_q;
            end
          end
          title_upd_d = 1'b1;
          upd_slot_d  = slot_q;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Flow control and busy are registered from the state being entered.
    rx_ready_d = (state_d != COMMIT);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      cnt_q       <= '0;
      shadow_q    <= {TITLE_CHARS{CH_SPACE}};
      titles_q    <= {INIT2, INIT1, INIT0};
      title_upd_q <= 1'b0;
      upd_slot_q  <= '0;
      frame_err_q <= 1'b0;
      rx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      titles_q    <= titles_d;
      title_upd_q <= title_upd_d;
      upd_slot_q  <= upd_slot_d;
      frame_err_q <= frame_err_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign titles    = titles_q;
  assign title_upd = title_upd_q;
  assign upd_slot  = upd_slot_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_title_loader.sv
// Self-checking bench for title_loader: one instance with immediate commit
// (distinct INIT values) and one with frame-aligned commit (default INITs).
module tb_title_loader;

  typedef logic [7:0] bq_t[$];

  localparam logic [79:0] I0 = 80'h30202020202020202020;
  localparam logic [79:0] I1 = 80'h31202020202020202020;
  localparam logic [79:0] I2 = 80'h32202020202020202020;
  localparam logic [79:0] SP = 80'h20202020202020202020;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  logic frame = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  bit sel = 1'b0;

  logic rx_valid0, rx_ready0, title_upd0, frame_err0, busy0;
  logic rx_valid1, rx_ready1, title_upd1, frame_err1, busy1;
  logic [1:0] upd_slot0, upd_slot1;
  logic [2:0][79:0] titles0, titles1;

  assign rx_valid0 = rx_valid && !sel;
  assign rx_valid1 = rx_valid && sel;

  always #5 clk_pix = ~clk_pix;

  title_loader #(.SYNC_COMMIT(1'b0), .INIT0(I0), .INIT1(I1), .INIT2(I2)) dut0 (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame),
    .rx_data(rx_data), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .titles(titles0), .title_upd(title_upd0), .upd_slot(upd_slot0),
    .frame_err(frame_err0), .busy(busy0)
  );

  title_loader #(.SYNC_COMMIT(1'b1)) dut1 (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame),
    .rx_data(rx_data), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .titles(titles1), .title_upd(title_upd1), .upd_slot(upd_slot1),
    .frame_err(frame_err1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  int upd_cnt0 = 0, err_cnt0 = 0, upd_cnt1 = 0, err_cnt1 = 0;
  logic [79:0] exp0 [3];

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk_pix) begin
    if (!rst_pix) begin
      if (title_upd0) upd_cnt0++;
      if (frame_err0) err_cnt0++;
      if (title_upd1) upd_cnt1++;
      if (frame_err1) err_cnt1++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected title from the record's chars: upper-case letters, '?' for the
  // glyphs above 0x5F, space padding to 10 chars.
  function automatic logic [79:0] model_title(input bq_t cs);
    logic [79:0] t;
    logic [7:0] c, m;
    t = '0;
    for (int i = 0; i < 10; i++) begin
      c = (i < cs.size()) ? cs[i] : 8'h20;
      if (c >= 8'h61 && c <= 8'h7A) m = c - 8'd32;
      else if (c > 8'h5F) m = 8'h3F;
      else m = c;
      t = {t[71:0], m};
    end
    return t;
  endfunction

  task automatic send(input logic [7:0] b, input bit fr);
    int n;
    n = 0;
    @(negedge clk_pix);
    rx_data = b;
    rx_valid = 1'b1;
    frame = fr;
    while (((sel ? rx_ready1 : rx_ready0) !== 1'b1) && n < 200) begin
      @(negedge clk_pix);
      n++;
    end
    if (n >= 200) chk("send_ready_timeout", 80'(sel ? rx_ready1 : rx_ready0), 80'd1);
    @(posedge clk_pix);
    #1;
    rx_valid = 1'b0;
    frame = 1'b0;
  endtask

  task automatic send_rec(input logic [7:0] s, input bq_t cs, input bit has_term,
                          input logic [7:0] term);
    send(8'h01, 1'b0);
    send(s, 1'b0);
    foreach (cs[i]) send(cs[i], 1'b0);
    if (has_term) send(term, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_pix);
    rst_pix = 1'b1;
    repeat (2) @(negedge clk_pix);
    rst_pix = 1'b0;
    exp0[0] = I0;
    exp0[1] = I1;
    exp0[2] = I2;
  endtask

  task automatic chk_titles0(input string tag);
    for (int k = 0; k < 3; k++) chk($sformatf("%s_t%0d", tag, k), titles0[k], exp0[k]);
  endtask

  initial begin
    bq_t cs;
    int u0, e0, u1, e1, len;
    logic [7:0] s, term;
    bit has_term;

    do_reset();
    #1;
    // Reset state of both instances.
    chk_titles0("reset");
    for (int k = 0; k < 3; k++) chk($sformatf("reset1_t%0d", k), titles1[k], SP);
    chk("reset_ready0", 80'(rx_ready0), 80'd1);
    chk("reset_busy0", 80'(busy0), 80'd0);
    chk("reset_upd0", 80'(title_upd0), 80'd0);
    chk("reset_slot0", 80'(upd_slot0), 80'd0);
    chk("reset_err0", 80'(frame_err0), 80'd0);
    chk("reset_ready1", 80'(rx_ready1), 80'd1);
    chk("reset_busy1", 80'(busy1), 80'd0);

    // "Hi" into slot 1 with exact commit timing.
    sel = 1'b0;
    cs = '{8'h48, 8'h69};
    send_rec(8'h31, cs, 1'b1, 8'h0A);
    chk("hi_commit_ready", 80'(rx_ready0), 80'd0);
    chk("hi_commit_busy", 80'(busy0), 80'd1);
    chk("hi_commit_noupd", 80'(title_upd0), 80'd0);
    chk("hi_pre_t1", titles0[1], I1);
    @(posedge clk_pix); #1;
    exp0[1] = model_title(cs);
    chk("hi_upd", 80'(title_upd0), 80'd1);
    chk("hi_slot", 80'(upd_slot0), 80'd1);
    chk("hi_value", titles0[1], 80'h48492020202020202020);
    chk_titles0("hi");
    @(posedge clk_pix); #1;
    chk("hi_upd_drop", 80'(title_upd0), 80'd0);
    chk("hi_idle_busy", 80'(busy0), 80'd0);
    chk("hi_idle_ready", 80'(rx_ready0), 80'd1);

    // Ten chars end the record; two trailing bytes are discarded silently.
    u0 = upd_cnt0; e0 = err_cnt0;
    cs = {};
    for (int i = 0; i < 12; i++) cs.push_back(8'h61);
    send_rec(8'h32, cs, 1'b0, 8'h00);
    repeat (3) @(posedge clk_pix); #1;
    cs = cs[0:9];
    exp0[2] = model_title(cs);
    chk("ten_value", titles0[2], 80'h41414141414141414141);
    chk_titles0("ten");
    chk("ten_upd_cnt", 80'(upd_cnt0 - u0), 80'd1);
    chk("ten_err_cnt", 80'(err_cnt0 - e0), 80'd0);

    // Bad slot byte, then an SOH restart inside a record.
    u0 = upd_cnt0; e0 = err_cnt0;
    send(8'h01, 1'b0);
    send(8'h33, 1'b0);
    chk("badslot_err", 80'(frame_err0), 80'd1);
    chk("badslot_busy", 80'(busy0), 80'd0);
    send(8'h01, 1'b0); send(8'h30, 1'b0); send(8'h41, 1'b0);
    send(8'h01, 1'b0); send(8'h30, 1'b0); send(8'h42, 1'b0); send(8'h0D, 1'b0);
    repeat (3) @(posedge clk_pix); #1;
    exp0[0] = 80'h42202020202020202020;
    chk_titles0("restart");
    chk("restart_err_cnt", 80'(err_cnt0 - e0), 80'd2);
    chk("restart_upd_cnt", 80'(upd_cnt0 - u0), 80'd1);

    // Char mapping of the glyphs above 0x5F.
    cs = '{8'h60, 8'h7B, 8'h41};
    send_rec(8'h31, cs, 1'b1, 8'h0A);
    repeat (3) @(posedge clk_pix); #1;
    exp0[1] = model_title(cs);
    chk("map_value", titles0[1], 80'h3F3F4120202020202020);
    chk_titles0("map");

    // Control byte mid-record aborts without update.
    u0 = upd_cnt0;
    send(8'h01, 1'b0); send(8'h30, 1'b0); send(8'h51, 1'b0); send(8'h07, 1'b0);
    chk("ctl_err", 80'(frame_err0), 80'd1);
    chk("ctl_busy", 80'(busy0), 80'd0);
    repeat (3) @(posedge clk_pix); #1;
    chk("ctl_upd_cnt", 80'(upd_cnt0 - u0), 80'd0);
    chk_titles0("ctl");

    // Randomized well-formed records with idle-time noise.
    for (int r = 0; r < 30; r++) begin
      u0 = upd_cnt0; e0 = err_cnt0;
      if ($urandom_range(0, 1) == 1) send(8'($urandom_range(2, 255)), 1'b0);
      s = 8'h30 + 8'($urandom_range(0, 2));
      len = $urandom_range(0, 10);
      cs = {};
      for (int i = 0; i < len; i++) cs.push_back(8'($urandom_range(32, 126)));
      term = ($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D;
      has_term = (len < 10) || ($urandom_range(0, 1) == 1);
      send_rec(s, cs, has_term, term);
      repeat (3) @(posedge clk_pix); #1;
      exp0[s - 8'h30] = model_title(cs);
      chk_titles0($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_upd_cnt", r), 80'(upd_cnt0 - u0), 80'd1);
      chk($sformatf("rnd%0d_err_cnt", r), 80'(err_cnt0 - e0), 80'd0);
    end

    // Frame-aligned commit: a frame with the terminator does not count.
    sel = 1'b1;
    u1 = upd_cnt1; e1 = err_cnt1;
    send(8'h01, 1'b0); send(8'h30, 1'b0); send(8'h53, 1'b0);
    send(8'h0A, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_pix); #1;
      chk($sformatf("sync_wait%0d_ready", i), 80'(rx_ready1), 80'd0);
      chk($sformatf("sync_wait%0d_t0", i), titles1[0], SP);
    end
    @(negedge clk_pix);
    frame = 1'b1;
    @(posedge clk_pix); #1;
    frame = 1'b0;
    chk("sync_upd", 80'(title_upd1), 80'd1);
    chk("sync_slot", 80'(upd_slot1), 80'd0);
    chk("sync_t0", titles1[0], 80'h53202020202020202020);
    chk("sync_t1", titles1[1], SP);
    chk("sync_t2", titles1[2], SP);
    repeat (2) @(posedge clk_pix); #1;
    chk("sync_upd_cnt", 80'(upd_cnt1 - u1), 80'd1);
    chk("sync_err_cnt", 80'(err_cnt1 - e1), 80'd0);
    chk("sync_idle_busy", 80'(busy1), 80'd0);

    // Reset mid-record drops it and restores the INIT titles.
    sel = 1'b0;
    send(8'h01, 1'b0); send(8'h31, 1'b0); send(8'h58, 1'b0);
    do_reset();
    #1;
    chk_titles0("midrst");
    chk("midrst_busy", 80'(busy0), 80'd0);
    chk("midrst_ready", 80'(rx_ready0), 80'd1);
    chk("midrst_t1_dut1", titles1[0], SP);
    u0 = upd_cnt0;
    send(8'h0A, 1'b0);
    repeat (3) @(posedge clk_pix); #1;
    chk("midrst_lf_upd_cnt", 80'(upd_cnt0 - u0), 80'd0);
    chk_titles0("midrst_lf");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
